// File: rtl/button_event_ctrl.sv
// rtl/button_event_ctrl.sv - debounced multi-button SHORT/LONG/REPEAT classifier with round-robin event stream
// Optional feature macro: BUTTON_EVT_AUTO_REPEAT_EN (REPEAT events while held past LONG).
module button_event_ctrl #(
    parameter int N_BTN          = 4,
    parameter int TICK_DIV       = 250000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int LONG_TICKS     = 1200,
    parameter int REPEAT_TICKS   = 80,
    localparam int ID_W          = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_level,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic [1:0]       evt_type,
    output logic [7:0]       drop_cnt
);
    localparam int TCNT_W  = $clog2(TICK_DIV);
    localparam int DB_W    = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int CNT_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [TCNT_W-1:0] TICK_LAST = TCNT_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [1:0]        EVT_SHORT = 2'b00;
    localparam logic [1:0]        EVT_LONG  = 2'b01;
`ifdef BUTTON_EVT_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0]  REP_LAST   = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [1:0]        EVT_REPEAT = 2'b10;
`endif

    typedef enum logic [1:0] {S_IDLE, S_DOWN, S_HELD} state_t;

    logic [N_BTN-1:0]  sync1, sync2, level_q, rise, fall;
    logic [TCNT_W-1:0] tick_cnt;
    logic              tick;
    logic [DB_W-1:0]   db_cnt [N_BTN];

    state_t            state_q [N_BTN];
    state_t            state_d [N_BTN];
    logic [CNT_W-1:0]  cnt_q [N_BTN];
    logic [CNT_W-1:0]  cnt_d [N_BTN];
    logic [N_BTN-1:0]  post;
    logic [1:0]        post_type [N_BTN];

    logic [N_BTN-1:0]  slot_vld;
    logic [1:0]        slot_type [N_BTN];
    logic [ID_W-1:0]   last_grant;
    logic              hi_found, lo_found, win_found, arb_load;
    logic [ID_W-1:0]   hi_id, lo_id, win_id;
    logic [1:0]        hi_type, lo_type, win_type;
    logic [N_BTN-1:0]  grant, drop;

    assign tick = (tick_cnt == TICK_LAST);
    assign rise = btn_level & ~level_q;
    assign fall = ~btn_level & level_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            level_q   <= '0;
            btn_level <= '0;
            tick_cnt  <= '0;
            for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            level_q  <= btn_level;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                for (int i = 0; i < N_BTN; i++) begin
                    if (sync2[i] != btn_level[i]) begin
                        if (db_cnt[i] == DB_LAST) begin
                            btn_level[i] <= ~btn_level[i];
                            db_cnt[i]    <= '0;
                        end else begin
                            db_cnt[i] <= db_cnt[i] + 1'b1;
                        end
                    end else begin
                        db_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // One counter per button: hold time in DOWN, repeat interval in HELD.
    always_comb begin
        post = '0;
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            post_type[i] = EVT_SHORT;
            case (state_q[i])
                S_IDLE: begin
                    if (rise[i]) begin
                        state_d[i] = S_DOWN;
                        cnt_d[i]   = '0;
                    end
                end
                S_DOWN: begin
                    if (fall[i]) begin
                        post[i]    = 1'b1;
                        state_d[i] = S_IDLE;
                    end else if (tick) begin
                        if (cnt_q[i] == LONG_LAST) begin
                            post[i]      = 1'b1;
                            post_type[i] = EVT_LONG;
                            state_d[i]   = S_HELD;
                            cnt_d[i]     = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
                S_HELD: begin
                    if (fall[i]) begin
                        state_d[i] = S_IDLE;
                    end
`ifdef BUTTON_EVT_AUTO_REPEAT_EN
                    else if (tick) begin
                        if (cnt_q[i] == REP_LAST) begin
                            post[i]      = 1'b1;
                            post_type[i] = EVT_REPEAT;
                            cnt_d[i]     = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
`endif
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    // Round-robin: lowest valid index above last_grant wins, else lowest index at or below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        hi_type  = '0;
        lo_type  = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (slot_vld[i]) begin
                if (ID_W'(i) > last_grant) begin
                    hi_found = 1'b1;
                    hi_id    = ID_W'(i);
                    hi_type  = slot_type[i];
                end else begin
                    lo_found = 1'b1;
                    lo_id    = ID_W'(i);
                    lo_type  = slot_type[i];
                end
            end
        end
        win_found = hi_found | lo_found;
        win_id    = hi_found ? hi_id : lo_id;
        win_type  = hi_found ? hi_type : lo_type;
        arb_load  = !evt_valid || evt_ready;
        grant     = '0;
        drop      = '0;
        for (int i = 0; i < N_BTN; i++) begin
            grant[i] = arb_load && win_found && (win_id == ID_W'(i));
            drop[i]  = post[i] && slot_vld[i] && !grant[i];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            slot_vld   <= '0;
            last_grant <= ID_W'(N_BTN - 1);
            evt_valid  <= 1'b0;
            evt_id     <= '0;
            evt_type   <= '0;
            drop_cnt   <= '0;
            for (int i = 0; i < N_BTN; i++) slot_type[i] <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (post[i] && (!slot_vld[i] || grant[i])) begin
                    slot_vld[i]  <= 1'b1;
                    slot_type[i] <= post_type[i];
                end else if (grant[i]) begin
                    slot_vld[i] <= 1'b0;
                end
            end
            if ((|drop) && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (arb_load) begin
                evt_valid <= win_found;
                if (win_found) begin
                    evt_id     <= win_id;
                    evt_type   <= win_type;
                    last_grant <= win_id;
                end
            end
        end
    end
endmodule

// File: tb/tb_button_event_ctrl.sv
// tb/tb_button_event_ctrl.sv - directed self-checking bench for button_event_ctrl
module tb_button_event_ctrl;
    localparam int N_BTN = 4;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'b0000;
    logic [3:0] btn_level;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic [1:0] evt_id;
    logic [1:0] evt_type;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc_n    = 0;
    int vcnt     = 0;
    logic [1:0] q_id[$];
    logic [1:0] q_type[$];
    int         q_cyc[$];

    button_event_ctrl #(
        .N_BTN(N_BTN), .TICK_DIV(4), .DEBOUNCE_TICKS(2), .LONG_TICKS(8), .REPEAT_TICKS(3)
    ) dut (
        .clk_in(clk_in), .rst(rst), .btn(btn), .btn_level(btn_level),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_type(evt_type), .drop_cnt(drop_cnt)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc_n <= cyc_n + 1;

    always @(negedge clk_in) begin
        #2;
        if (!rst && evt_valid) begin
            vcnt++;
            if (evt_ready) begin
                q_id.push_back(evt_id);
                q_type.push_back(evt_type);
                q_cyc.push_back(cyc_n);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge clk_in);
    endtask

    task automatic clear_log();
        q_id.delete();
        q_type.delete();
        q_cyc.delete();
        vcnt = 0;
    endtask

    task automatic do_reset();
        btn = 4'b0000;
        evt_ready = 1'b1;
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        clear_log();
    endtask

    task automatic wait_level(input logic [1:0] idx, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (btn_level[idx]) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        btn = 4'b1111;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_checks++;
            if ({btn_level, evt_valid, evt_id, evt_type, drop_cnt} !== 17'h0) begin
                n_fails++;
                $display("FAIL reset_outputs: got %0h, expected 0", {btn_level, evt_valid, evt_id, evt_type, drop_cnt});
            end
        end
        rst = 1'b0;
        repeat (7) cyc();
        n_checks++;
        if (btn_level !== 4'b0000) begin
            n_fails++;
            $display("FAIL level_before_2nd_tick: got %b, expected 0000", btn_level);
        end
        cyc();
        n_checks++;
        if (btn_level !== 4'b1111) begin
            n_fails++;
            $display("FAIL level_after_2nd_tick: got %b, expected 1111", btn_level);
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        btn = 4'b0000;
        repeat (40) cyc();
        n_checks++;
        if (q_id.size() != 4) begin
            n_fails++;
            $display("FAIL b2b_count: got %0d events, expected 4", q_id.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if ({q_id[k], q_type[k]} !== {2'(k), 2'b00}) begin
                    n_fails++;
                    $display("FAIL b2b_event%0d: got id %0d type %b, expected id %0d type 00", k, q_id[k], q_type[k], k);
                end
                n_checks++;
                if (q_cyc[k] - q_cyc[0] != k) begin
                    n_fails++;
                    $display("FAIL b2b_spacing%0d: got %0d, expected %0d", k, q_cyc[k] - q_cyc[0], k);
                end
            end
        end
    endtask

    task automatic test_short_press();
        do_reset();
        btn = 4'b0100;
        repeat (20) cyc();
        btn = 4'b0000;
        repeat (40) cyc();
        n_checks++;
        if (q_id.size() != 1) begin
            n_fails++;
            $display("FAIL short_count: got %0d, expected 1", q_id.size());
        end else begin
            n_checks++;
            if ({q_id[0], q_type[0]} !== 4'b1000) begin
                n_fails++;
                $display("FAIL short_event: got id %0d type %b, expected id 2 type 00", q_id[0], q_type[0]);
            end
        end
        n_checks++;
        if (vcnt != 1) begin
            n_fails++;
            $display("FAIL short_valid_cycles: got %0d, expected 1", vcnt);
        end
    endtask

    task automatic test_long_press();
        bit ok;
        do_reset();
        btn = 4'b0010;
        wait_level(2'd1, ok);
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL long_rise_timeout: got no rise, expected btn_level[1]=1");
        end
        repeat (32) cyc();
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL long_early: got evt_valid %b, expected 0", evt_valid);
        end
        cyc();
        n_checks++;
        if ({evt_valid, evt_id, evt_type} !== 5'b1_01_01) begin
            n_fails++;
            $display("FAIL long_event: got %b, expected 10101", {evt_valid, evt_id, evt_type});
        end
        repeat (47) cyc();
        btn = 4'b0000;
        repeat (40) cyc();
`ifdef BUTTON_EVT_AUTO_REPEAT_EN
        n_checks++;
        if (q_id.size() != 5) begin
            n_fails++;
            $display("FAIL long_repeat_count: got %0d, expected 5", q_id.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if ({q_id[k], q_type[k]} !== {2'd1, (k == 0) ? 2'b01 : 2'b10}) begin
                    n_fails++;
                    $display("FAIL long_repeat_event%0d: got id %0d type %b", k, q_id[k], q_type[k]);
                end
                if (k > 0) begin
                    n_checks++;
                    if (q_cyc[k] - q_cyc[k-1] != 12) begin
                        n_fails++;
                        $display("FAIL repeat_spacing%0d: got %0d cycles, expected 12", k, q_cyc[k] - q_cyc[k-1]);
                    end
                end
            end
        end
`else
        n_checks++;
        if (q_id.size() != 1 || q_type[0] !== 2'b01) begin
            n_fails++;
            $display("FAIL long_only: got %0d events, expected a single LONG", q_id.size());
        end
`endif
    endtask

    task automatic test_round_robin();
        int bad;
        bit seen;
        do_reset();
        btn = 4'b1001;
        repeat (20) cyc();
        evt_ready = 1'b0;
        btn = 4'b0000;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cyc();
            seen = evt_valid;
        end
        n_checks++;
        if ({seen, evt_id, evt_type} !== 5'b1_00_00) begin
            n_fails++;
            $display("FAIL rr_first: got %b, expected 10000", {seen, evt_id, evt_type});
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if ({evt_valid, evt_id, evt_type} !== 5'b1_00_00) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fails++;
            $display("FAIL rr_hold_stable: got %0d unstable cycles, expected 0", bad);
        end
        evt_ready = 1'b1;
        cyc();
        n_checks++;
        if ({evt_valid, evt_id, evt_type} !== 5'b1_11_00) begin
            n_fails++;
            $display("FAIL rr_second: got %b, expected 11100", {evt_valid, evt_id, evt_type});
        end
        cyc();
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL rr_drain: got evt_valid %b, expected 0", evt_valid);
        end
        clear_log();
        btn = 4'b1001;
        repeat (20) cyc();
        btn = 4'b0000;
        repeat (40) cyc();
        n_checks++;
        if (q_id.size() != 2 || q_id[0] !== 2'd0 || q_id[1] !== 2'd3) begin
            n_fails++;
            $display("FAIL rr_repeat_order: got %0d events, expected id 0 then id 3", q_id.size());
        end
    endtask

    task automatic test_overflow();
        bit ok;
        do_reset();
        evt_ready = 1'b0;
        btn = 4'b0010;
        wait_level(2'd1, ok);
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL ovf_rise_timeout: got no rise, expected btn_level[1]=1");
        end
        repeat (80) cyc();
        btn = 4'b0000;
        n_checks++;
        if ({evt_valid, evt_id, evt_type} !== 5'b1_01_01) begin
            n_fails++;
            $display("FAIL ovf_held_long: got %b, expected 10101", {evt_valid, evt_id, evt_type});
        end
`ifdef BUTTON_EVT_AUTO_REPEAT_EN
        n_checks++;
        if (drop_cnt !== 8'd3) begin
            n_fails++;
            $display("FAIL ovf_drop_cnt: got %0d, expected 3", drop_cnt);
        end
        evt_ready = 1'b1;
        cyc();
        n_checks++;
        if ({evt_valid, evt_id, evt_type} !== 5'b1_01_10) begin
            n_fails++;
            $display("FAIL ovf_slot_repeat: got %b, expected 10110", {evt_valid, evt_id, evt_type});
        end
`else
        n_checks++;
        if (drop_cnt !== 8'd0) begin
            n_fails++;
            $display("FAIL ovf_drop_cnt: got %0d, expected 0", drop_cnt);
        end
        evt_ready = 1'b1;
`endif
        cyc();
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL ovf_drain: got evt_valid %b, expected 0", evt_valid);
        end
        repeat (40) cyc();
    endtask

    task automatic test_drop_saturation();
        do_reset();
        evt_ready = 1'b0;
        for (int k = 0; k < 260; k++) begin
            btn = 4'b0100;
            repeat (16) cyc();
            btn = 4'b0000;
            repeat (16) cyc();
            if (k == 2) begin
                n_checks++;
                if (drop_cnt !== 8'd1) begin
                    n_fails++;
                    $display("FAIL drop_first: got %0d, expected 1", drop_cnt);
                end
            end
        end
        n_checks++;
        if (drop_cnt !== 8'd255) begin
            n_fails++;
            $display("FAIL drop_saturate: got %0d, expected 255", drop_cnt);
        end
        n_checks++;
        if ({evt_valid, evt_id, evt_type} !== 5'b1_10_00) begin
            n_fails++;
            $display("FAIL drop_oldest_kept: got %b, expected 11000", {evt_valid, evt_id, evt_type});
        end
    endtask

    task automatic test_reset_midstream();
        rst = 1'b1;
        cyc();
        n_checks++;
        if ({evt_valid, drop_cnt} !== 9'h0) begin
            n_fails++;
            $display("FAIL midrst_clear: got %h, expected 0", {evt_valid, drop_cnt});
        end
        rst = 1'b0;
        evt_ready = 1'b1;
        clear_log();
        repeat (40) cyc();
        n_checks++;
        if (vcnt != 0 || q_id.size() != 0) begin
            n_fails++;
            $display("FAIL midrst_stale: got %0d valid cycles, expected 0", vcnt);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_short_press();
        test_long_press();
        test_round_robin();
        test_overflow();
        test_drop_saturation();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
